// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: a shared prescaled period counter drives CHANNELS outputs,
// with period/duty shadowed to period boundaries. Optional macro: PWM_POLARITY_EN.
module pwm_timer_multi #(
    parameter int BITS     = 15,
    parameter int CHANNELS = 4,
    parameter int PRE_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     load,
    input  logic                     mode,
    input  logic [PRE_BITS-1:0]      prescale,
    input  logic [BITS-1:0]          period,
    input  logic [CHANNELS*BITS-1:0] duty,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0]      polarity,
`endif
    output logic [CHANNELS-1:0]      pwm_out,
    output logic                     done,
    output logic                     busy,
    output logic [BITS-1:0]          count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRE_BITS-1:0] PRE_ONE = PRE_BITS'(1);
    localparam logic [BITS-1:0]     CNT_ONE = BITS'(1);

    state_t                     state_q, state_d;
    logic [PRE_BITS-1:0]        pre_cnt_q, pre_cnt_d;
    logic [BITS-1:0]            count_q, count_d;
    logic                       load_pending_q, load_pending_d;
    logic                       mode_s_q, mode_s_d;
    logic [BITS-1:0]            period_s_q, period_s_d;
    logic [CHANNELS*BITS-1:0]   duty_s_q, duty_s_d;
    logic                       done_q, done_d;

    logic                       tick;
    logic                       wrap;
    logic [CHANNELS-1:0]        pwm_raw;

    assign tick = (state_q == RUN) && enable && (pre_cnt_q == prescale);
    assign wrap = tick && (count_q == period_s_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pre_cnt_q      <= '0;
            count_q        <= '0;
            load_pending_q <= 1'b0;
            mode_s_q       <= 1'b0;
            period_s_q     <= '0;
            duty_s_q       <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_cnt_q      <= pre_cnt_d;
            count_q        <= count_d;
            load_pending_q <= load_pending_d;
            mode_s_q       <= mode_s_d;
            period_s_q     <= period_s_d;
            duty_s_q       <= duty_s_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pre_cnt_d      = pre_cnt_q;
        count_d        = count_q;
        load_pending_d = load_pending_q;
        mode_s_d       = mode_s_q;
        period_s_d     = period_s_q;
        duty_s_d       = duty_s_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d        = RUN;
                    period_s_d     = period;
                    duty_s_d       = duty;
                    mode_s_d       = mode;
                    pre_cnt_d      = '0;
                    count_d        = '0;
                    load_pending_d = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d        = IDLE;
                    pre_cnt_d      = '0;
                    count_d        = '0;
                    load_pending_d = 1'b0;
                end else begin
                    if (load) load_pending_d = 1'b1;
                    if (enable) pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
                    if (tick) count_d = wrap ? '0 : count_q + CNT_ONE;
                    // A load on the wrap edge itself is honoured at that same wrap.
                    if (wrap) begin
                        done_d = 1'b1;
                        if (load_pending_q || load) begin
                            period_s_d     = period;
                            duty_s_d       = duty;
                            load_pending_d = 1'b0;
                        end
                        if (mode_s_q) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pwm_raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_raw[i] = (state_q == RUN) && (count_q < duty_s_q[i*BITS +: BITS]);
        end
    end

`ifdef PWM_POLARITY_EN
    assign pwm_out = pwm_raw ^ polarity;
`else
    assign pwm_out = pwm_raw;
`endif
    assign done  = done_q;
    assign busy  = (state_q == RUN);
    assign count = count_q;

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Directed bench for pwm_timer_multi: hand-computed counter/PWM/done sequences.
module tb_pwm_timer_multi;

    logic        clk;
    logic        reset_n;
    logic        enable, start, stop, load, mode;
    logic [7:0]  prescale;
    logic [14:0] period;
    logic [59:0] duty;
    logic [3:0]  pwm_out;
    logic        done, busy;
    logic [14:0] count;
`ifdef PWM_POLARITY_EN
    logic [3:0]  polarity;
`endif

    int n_vec;
    int n_err;

    pwm_timer_multi dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .mode     (mode),
        .prescale (prescale),
        .period   (period),
        .duty     (duty),
`ifdef PWM_POLARITY_EN
        .polarity (polarity),
`endif
        .pwm_out  (pwm_out),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input logic [14:0] d3, input logic [14:0] d2,
                            input logic [14:0] d1, input logic [14:0] d0);
        duty = {d3, d2, d1, d0};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_count(input logic [14:0] tgt, input int budget);
        int n;
        n = 0;
        while (count !== tgt && n < budget) begin
            step();
            n++;
        end
        chk("wait_cnt", 32'(count), 32'(tgt));
    endtask

    initial begin
        int h0, h1, h2, h3, dn, c;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        mode = 1'b0; prescale = 8'd0; period = 15'd0; duty = '0;
`ifdef PWM_POLARITY_EN
        polarity = 4'b0000;
`endif
        #12;
        chk("rst_cnt",  32'(count),   0);
        chk("rst_busy", 32'(busy),    0);
        chk("rst_pwm",  32'(pwm_out), 0);
        chk("rst_done", 32'(done),    0);
        step();
        reset_n = 1'b1;
        step();

        // continuous, prescale 0, period 9
        period = 15'd9;
        set_duty(15'd12, 15'd10, 15'd3, 15'd0);
        pulse_start();
        h0 = 0; h1 = 0; h2 = 0; h3 = 0; dn = 0;
        for (int k = 0; k < 30; k++) begin
            chk("a_cnt", 32'(count), 32'(k % 10));
            h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]); h3 += int'(pwm_out[3]);
            dn += int'(done);
            step();
        end
        chk("a_ch0", 32'(h0), 0);
        chk("a_ch1", 32'(h1), 9);
        chk("a_ch2", 32'(h2), 30);
        chk("a_ch3", 32'(h3), 30);
        chk("a_done", 32'(dn), 2);
        chk("a_done_wrap", 32'(done), 1);
        wait_count(15'd6, 20);
        pulse_stop();
        chk("stop_cnt",  32'(count), 0);
        chk("stop_busy", 32'(busy),  0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy),  0);
        chk("ss_cnt",  32'(count), 0);

        // prescale 2, period 4, ch1 duty 2, with an enable freeze
        prescale = 8'd2;
        period = 15'd4;
        set_duty(15'd0, 15'd0, 15'd2, 15'd0);
        pulse_start();
        h1 = 0; dn = 0;
        for (int k = 0; k < 30; k++) begin
            chk("b_cnt", 32'(count), 32'((k / 3) % 5));
            h1 += int'(pwm_out[1]);
            dn += int'(done);
            if (k == 20) begin
                enable = 1'b0;
                for (int j = 0; j < 7; j++) begin
                    step();
                    chk("b_frz_cnt",  32'(count),      1);
                    chk("b_frz_pwm",  32'(pwm_out[1]), 1);
                    chk("b_frz_done", 32'(done),       0);
                end
                enable = 1'b1;
            end
            step();
        end
        chk("b_ch1", 32'(h1), 12);
        chk("b_done", 32'(dn), 1);
        chk("b_wrap_done", 32'(done), 1);
        chk("b_wrap_cnt",  32'(count), 0);
        pulse_stop();
        prescale = 8'd0;

        // shadow update mid-period, then a load on the wrap edge
        period = 15'd9;
        set_duty(15'd0, 15'd0, 15'd5, 15'd0);
        pulse_start();
        step(); step(); step();
        chk("c_cnt3", 32'(count), 3);
        load = 1'b1;
        period = 15'd4;
        set_duty(15'd0, 15'd0, 15'd1, 15'd0);
        step();
        load = 1'b0;
        for (int k = 4; k < 19; k++) begin
            c = (k < 10) ? k : (k - 10) % 5;
            chk("c_cnt",  32'(count),      32'(c));
            chk("c_pwm1", 32'(pwm_out[1]), (k < 10) ? 32'(k < 5) : 32'(c < 1));
            chk("c_done", 32'(done),       32'(k == 10 || k == 15));
            step();
        end
        chk("c_pre_wrap", 32'(count), 4);
        load = 1'b1;
        period = 15'd2;
        set_duty(15'd0, 15'd0, 15'd2, 15'd0);
        step();
        load = 1'b0;
        for (int k = 20; k < 26; k++) begin
            c = (k - 20) % 3;
            chk("c2_cnt",  32'(count),      32'(c));
            chk("c2_pwm1", 32'(pwm_out[1]), 32'(c < 2));
            chk("c2_done", 32'(done),       32'(k == 20 || k == 23));
            step();
        end
        pulse_stop();

        // one-shot, period 7, ch0 duty 4; start mid-run is ignored
        mode = 1'b1;
        period = 15'd7;
        set_duty(15'd0, 15'd0, 15'd0, 15'd4);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            chk("d_cnt",  32'(count),      32'(k));
            chk("d_pwm0", 32'(pwm_out[0]), 32'(k < 4));
            chk("d_busy", 32'(busy),       1);
            if (k == 2) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("d_done", 32'(done),    1);
        chk("d_busy_end", 32'(busy), 0);
        chk("d_cnt_end", 32'(count), 0);
        chk("d_pwm_end", 32'(pwm_out), 0);
        step();
        chk("d_done_once", 32'(done), 0);
        chk("d_idle", 32'(busy), 0);
        mode = 1'b0;

        // asynchronous reset while running
        period = 15'd9;
        set_duty(15'd12, 15'd10, 15'd3, 15'd0);
        pulse_start();
        step(); step(); step(); step(); step();
        chk("e_cnt5", 32'(count), 5);
        chk("e_pwm5", 32'(pwm_out), 32'(4'b1100));
        #1;
        reset_n = 1'b0;
        #1;
        chk("e_rst_cnt",  32'(count),   0);
        chk("e_rst_busy", 32'(busy),    0);
        chk("e_rst_pwm",  32'(pwm_out), 0);
        step();
        reset_n = 1'b1;
        step();

`ifdef PWM_POLARITY_EN
        polarity = 4'b0010;
        #1;
        chk("p_idle", 32'(pwm_out), 32'(4'b0010));
        period = 15'd9;
        set_duty(15'd0, 15'd0, 15'd3, 15'd0);
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            chk("p_pwm", 32'(pwm_out), 32'({2'b00, !(k < 3), 1'b0}));
            step();
        end
        pulse_stop();
        chk("p_stop", 32'(pwm_out), 32'(4'b0010));
        polarity = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
